conv_layer_line_buffer: RTL and testbench

//  - Parametrised row ring buffer feeding the conv layer kernel array: stores NUM_ROWS image rows of ROW_LEN words.
//  - Loads one row word-by-word per LOAD command and rotates so the newest row is always logical row NUM_ROWS-1.
//  - Presents any logical row as one registered parallel bus.
//  - Sits between the input pixel stream and the conv kernel row shifter.

---
 rtl/conv_layer_line_buffer.sv | 135 +++++++++++++
 tb/tb_conv_layer_line_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : conv_layer_line_buffer
// Brief    : Row ring buffer for the conv kernel array. It loads rows word by
//            word and presents any logical row as a registered parallel bus.
//            Optional macro CONV_BUF_BIAS_ROW_EN adds a bias row of float 1.0
//            at row_sel == NUM_ROWS.
// Revision : 1.0 - initial release
// ============================================================================
module conv_layer_line_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ROW_LEN       = 8,
    parameter int NUM_ROWS      = 3,
    parameter int ROW_IDX_WIDTH = 2,
    parameter int COL_IDX_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     buffer_cmd,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           data_valid,
    input  logic [ROW_IDX_WIDTH-1:0]       row_sel,
    output logic                           buffer_ack,
    output logic                           busy,
    output logic                           rows_full,
    output logic                           out_valid,
    output logic [ROW_LEN*DATA_WIDTH-1:0]  data_out_bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    localparam logic [1:0] c_cmd_load  = 2'd1;
    localparam logic [1:0] c_cmd_read  = 2'd2;
    localparam logic [1:0] c_cmd_clear = 2'd3;

    localparam logic [ROW_IDX_WIDTH-1:0] c_num_rows     = ROW_IDX_WIDTH'(NUM_ROWS);
    localparam logic [ROW_IDX_WIDTH-1:0] c_last_row     = ROW_IDX_WIDTH'(NUM_ROWS - 1);
    localparam logic [ROW_IDX_WIDTH:0]   c_num_rows_ext = (ROW_IDX_WIDTH + 1)'(NUM_ROWS);
    localparam logic [COL_IDX_WIDTH-1:0] c_last_col     = COL_IDX_WIDTH'(ROW_LEN - 1);

    state_t                      r_state;
    logic [DATA_WIDTH-1:0]       r_rows [NUM_ROWS][ROW_LEN];
    logic [ROW_IDX_WIDTH-1:0]    r_wr_ptr;
    logic [ROW_IDX_WIDTH-1:0]    r_rows_cnt;
    logic [COL_IDX_WIDTH-1:0]    r_col_cnt;

    logic [ROW_IDX_WIDTH:0]          w_sum;
    logic [ROW_IDX_WIDTH:0]          w_phys_ext;
    logic [ROW_IDX_WIDTH-1:0]        w_phys;
    logic                            w_row_loaded;
    logic [ROW_LEN*DATA_WIDTH-1:0]   w_read_bus;

    // Logical k maps to physical (wr_ptr + k) mod NUM_ROWS; rows older than
    // the loaded count are forced to zero so partial aborted data never leaks.
    always_comb begin
        w_sum        = {1'b0, r_wr_ptr} + {1'b0, row_sel};
        w_phys_ext   = (w_sum >= c_num_rows_ext) ? (w_sum - c_num_rows_ext) : w_sum;
        w_phys       = w_phys_ext[ROW_IDX_WIDTH-1:0];
        w_row_loaded = (({1'b0, row_sel} + {1'b0, r_rows_cnt}) >= c_num_rows_ext);
        w_read_bus   = '0;
        if ((row_sel < c_num_rows) && w_row_loaded) begin
            for (int c = 0; c < ROW_LEN; c++) begin
                w_read_bus[(ROW_LEN-1-c)*DATA_WIDTH +: DATA_WIDTH] = r_rows[w_phys][c];
            end
        end
`ifdef CONV_BUF_BIAS_ROW_EN
        else if (row_sel == c_num_rows) begin
            for (int c = 0; c < ROW_LEN; c++) begin
                w_read_bus[(ROW_LEN-1-c)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(32'h3F80_0000);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || (buffer_cmd == c_cmd_clear)) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < ROW_LEN; c++) begin
                    r_rows[r][c] <= '0;
                end
            end
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rows_cnt   <= '0;
            r_col_cnt    <= '0;
            data_out_bus <= '0;
            buffer_ack   <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            rows_full    <= 1'b0;
        end else begin
            buffer_ack <= 1'b0;
            out_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (buffer_cmd == c_cmd_load) begin
                        r_state   <= S_LOAD;
                        busy      <= 1'b1;
                        r_col_cnt <= '0;
                    end else if (buffer_cmd == c_cmd_read) begin
                        data_out_bus <= w_read_bus;
                        out_valid    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (buffer_cmd == c_cmd_read) begin
                        // Abort: partial words stay, pointers untouched
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (data_valid) begin
                        r_rows[r_wr_ptr][r_col_cnt] <= data_in;
                        if (r_col_cnt == c_last_col) begin
                            r_state    <= S_IDLE;
                            busy       <= 1'b0;
                            buffer_ack <= 1'b1;
                            r_col_cnt  <= '0;
                            r_wr_ptr   <= (r_wr_ptr == c_last_row) ? '0 : r_wr_ptr + 1'b1;
                            if (r_rows_cnt != c_num_rows) begin
                                r_rows_cnt <= r_rows_cnt + 1'b1;
                            end
                            rows_full  <= (r_rows_cnt == c_last_row) || (r_rows_cnt == c_num_rows);
                        end else begin
                            r_col_cnt <= r_col_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_layer_line_buffer
// Brief    : Directed self-checking bench for conv_layer_line_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_layer_line_buffer;

    localparam int DW = 32;
    localparam int RL = 8;
    localparam int NR = 3;
    localparam int RW = 2;
    localparam int CW = 3;
    localparam int BW = DW * RL;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    buffer_cmd;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic [RW-1:0] row_sel;
    logic          buffer_ack;
    logic          busy;
    logic          rows_full;
    logic          out_valid;
    logic [BW-1:0] data_out_bus;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    conv_layer_line_buffer #(
        .DATA_WIDTH    (DW),
        .ROW_LEN       (RL),
        .NUM_ROWS      (NR),
        .ROW_IDX_WIDTH (RW),
        .COL_IDX_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buffer_cmd   (buffer_cmd),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .row_sel      (row_sel),
        .buffer_ack   (buffer_ack),
        .busy         (busy),
        .rows_full    (rows_full),
        .out_valid    (out_valid),
        .data_out_bus (data_out_bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] mk_row(input logic [DW-1:0] base);
        logic [BW-1:0] r;
        r = '0;
        for (int c = 0; c < RL; c++) r[(RL-1-c)*DW +: DW] = base + DW'(c);
        return r;
    endfunction

    function automatic logic [BW-1:0] mk_const(input logic [DW-1:0] w);
        logic [BW-1:0] r;
        for (int c = 0; c < RL; c++) r[(RL-1-c)*DW +: DW] = w;
        return r;
    endfunction

    task automatic read_row(input logic [RW-1:0] sel, input logic [BW-1:0] exp, input string name);
        buffer_cmd = 2'd2;
        row_sel    = sel;
        step();
        buffer_cmd = 2'd0;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s out_valid got %b expected 1", name, out_valid);
        end
        n_tests++;
        if (data_out_bus !== exp) begin
            n_fail++;
            $display("FAIL %s data got %h expected %h", name, data_out_bus, exp);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || data_out_bus !== exp) begin
            n_fail++;
            $display("FAIL %s_hold out_valid %b data %h expected 0 / %h", name, out_valid, data_out_bus, exp);
        end
    endtask

    task automatic load_row(input logic [DW-1:0] base, input bit gap, input string name);
        buffer_cmd = 2'd1;
        step();
        buffer_cmd = 2'd0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy got %b expected 1", name, busy);
        end
        for (int i = 0; i < RL; i++) begin
            if (gap) begin
                data_valid = 1'b0;
                step();
                step();
            end
            data_valid = 1'b1;
            data_in    = base + DW'(i);
            step();
            data_valid = 1'b0;
            n_tests++;
            if (i < RL - 1) begin
                if (buffer_ack !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_word%0d ack %b busy %b expected 0 1", name, i, buffer_ack, busy);
                end
            end else begin
                if (buffer_ack !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_done ack %b busy %b expected 1 0", name, buffer_ack, busy);
                end
            end
        end
        step();
        n_tests++;
        if (buffer_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ack_pulse got %b expected 0", name, buffer_ack);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; buffer_cmd = 2'd0; data_in = '0; data_valid = 1'b0; row_sel = '0;
        step();
        step();
        n_tests++;
        if ({buffer_ack, busy, rows_full, out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b expected 0000", {buffer_ack, busy, rows_full, out_valid});
        end
        n_tests++;
        if (data_out_bus !== '0) begin
            n_fail++;
            $display("FAIL reset_bus got %h expected 0", data_out_bus);
        end
        rst = 1'b0;
        read_row(2'd2, '0, "reset_read2");
    endtask

    task automatic test_load_abc();
        load_row(32'h10, 1'b0, "load_a");
        n_tests++;
        if (rows_full !== 1'b0) begin
            n_fail++;
            $display("FAIL rows_full_a got %b expected 0", rows_full);
        end
        read_row(2'd2, mk_row(32'h10), "partial_read2");
        read_row(2'd0, '0, "partial_read0");
        load_row(32'h20, 1'b0, "load_b");
        n_tests++;
        if (rows_full !== 1'b0) begin
            n_fail++;
            $display("FAIL rows_full_b got %b expected 0", rows_full);
        end
        load_row(32'h30, 1'b0, "load_c");
        n_tests++;
        if (rows_full !== 1'b1) begin
            n_fail++;
            $display("FAIL rows_full_c got %b expected 1", rows_full);
        end
        read_row(2'd0, mk_row(32'h10), "abc_read0");
        n_tests++;
        if (data_out_bus[255:224] !== 32'h10) begin
            n_fail++;
            $display("FAIL word0_msb got %h expected 00000010", data_out_bus[255:224]);
        end
        read_row(2'd1, mk_row(32'h20), "abc_read1");
        read_row(2'd2, mk_row(32'h30), "abc_read2");
    endtask

    task automatic test_wrap();
        load_row(32'h40, 1'b0, "load_d");
        read_row(2'd0, mk_row(32'h20), "wrap_read0");
        read_row(2'd1, mk_row(32'h30), "wrap_read1");
        read_row(2'd2, mk_row(32'h40), "wrap_read2");
    endtask

    task automatic test_gaps();
        load_row(32'h70, 1'b1, "load_gap");
        read_row(2'd2, mk_row(32'h70), "gap_read2");
        read_row(2'd0, mk_row(32'h30), "gap_read0");
        read_row(2'd1, mk_row(32'h40), "gap_read1");
    endtask

    task automatic test_abort();
        buffer_cmd = 2'd1;
        step();
        buffer_cmd = 2'd0;
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1;
            data_in    = 32'h50 + DW'(i);
            step();
        end
        data_valid = 1'b0;
        buffer_cmd = 2'd2;
        row_sel    = 2'd2;
        step();
        buffer_cmd = 2'd0;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rows_full !== 1'b1 || buffer_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flags ov %b busy %b full %b ack %b expected 0 0 1 0",
                     out_valid, busy, rows_full, buffer_ack);
        end
        n_tests++;
        if (data_out_bus !== mk_row(32'h40)) begin
            n_fail++;
            $display("FAIL abort_bus_hold got %h expected %h", data_out_bus, mk_row(32'h40));
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_valid got %b expected 0", out_valid);
        end
        load_row(32'h60, 1'b0, "load_e");
        read_row(2'd0, mk_row(32'h40), "abort_read0");
        read_row(2'd1, mk_row(32'h70), "abort_read1");
        read_row(2'd2, mk_row(32'h60), "abort_read2");
    endtask

    task automatic test_clear();
        logic [BW-1:0] exp3;
        buffer_cmd = 2'd1;
        step();
        buffer_cmd = 2'd0;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            data_in    = 32'h90 + DW'(i);
            step();
        end
        data_valid = 1'b0;
        buffer_cmd = 2'd3;
        step();
        buffer_cmd = 2'd0;
        n_tests++;
        if (busy !== 1'b0 || rows_full !== 1'b0 || buffer_ack !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flags busy %b full %b ack %b ov %b expected 0 0 0 0",
                     busy, rows_full, buffer_ack, out_valid);
        end
        n_tests++;
        if (data_out_bus !== '0) begin
            n_fail++;
            $display("FAIL clear_bus got %h expected 0", data_out_bus);
        end
        read_row(2'd0, '0, "clear_read0");
        read_row(2'd1, '0, "clear_read1");
        read_row(2'd2, '0, "clear_read2");
`ifdef CONV_BUF_BIAS_ROW_EN
        exp3 = mk_const(32'h3F80_0000);
`else
        exp3 = '0;
`endif
        read_row(2'd3, exp3, "clear_read3");
    endtask

    initial begin
        test_reset();
        test_load_abc();
        test_wrap();
        test_gaps();
        test_abort();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
